// File: rtl/bsr_pkg.sv
// Shared definitions for the bidirectional shift register family:
// FSM encodings, bit-order constants and a width helper.
package bsr_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/piso_shift_tx_if.sv
// Load handshake, shift enable and serial output bundle of the PISO transmitter.
interface piso_shift_tx_if #(
  parameter int MSB = 4
);
  logic [MSB-1:0] din;
  logic           dir;
  logic           load_valid;
  logic           load_ready;
  logic           en;
  logic           q;
  logic           q_valid;
  logic           busy;
  logic           frame_done;

  modport master (
    output din, dir, load_valid, en,
    input  load_ready, q, q_valid, busy, frame_done
  );

  modport slave (
    input  din, dir, load_valid, en,
    output load_ready, q, q_valid, busy, frame_done
  );
endinterface

// File: rtl/piso_shift_tx_bit_counter.sv
// Loadable down-counter tracking the bits left in a frame; o_last flags the
// final bit so the FSM can end or chain a frame on the same edge.
module shift_bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_last
);

  logic [W-1:0] r_cnt;

  // A load wins over a decrement so a chained frame restarts at full count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_last = (r_cnt == W'(1));

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: accepts a word on a valid/ready load
// and emits it one bit per enabled cycle in the latched bit order.
//
// state    | meaning
// ST_IDLE  | no frame; load_ready high, q_valid low
// ST_SHIFT | frame active; each en cycle consumes the bit on q
module piso_shift_tx
  import bsr_pkg::*;
#(
  parameter int MSB = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  piso_shift_tx_if.slave       bus
);

  localparam int             CW       = clog2(MSB + 1);
  localparam logic [CW-1:0]  CNT_INIT = CW'(MSB);

  state_t           r_state;
  logic [MSB-1:0]   r_shreg;
  logic             r_dir;
  logic             r_frame_done;

  logic             w_last;
  logic             w_shift;
  logic             w_load_ready;
  logic             w_load;

  assign w_shift      = (r_state == ST_SHIFT) && bus.en;
  // Ready on the last-bit cycle too, so frames can chain without a gap.
  assign w_load_ready = (r_state == ST_IDLE) || (w_shift && w_last);
  assign w_load       = bus.load_valid && w_load_ready;

  shift_bit_counter #(.W(CW)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (CNT_INIT),
    .i_dec      (w_shift),
    .o_last     (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_shreg      <= '0;
      r_dir        <= DIR_LSB_FIRST;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_shift && w_last;
      if (w_load) begin
        r_state <= ST_SHIFT;
        r_shreg <= bus.din;
        r_dir   <= bus.dir;
      end else if (w_shift) begin
        if (r_dir == DIR_MSB_FIRST) begin
          r_shreg <= {r_shreg[MSB-2:0], 1'b0};
        end else begin
          r_shreg <= {1'b0, r_shreg[MSB-1:1]};
        end
        if (w_last) begin
          r_state <= ST_IDLE;
        end
      end
    end
  end

  assign bus.q          = (r_dir == DIR_MSB_FIRST) ? r_shreg[MSB-1] : r_shreg[0];
  assign bus.q_valid    = (r_state == ST_SHIFT);
  assign bus.busy       = (r_state == ST_SHIFT);
  assign bus.frame_done = r_frame_done;
  assign bus.load_ready = w_load_ready;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: a scoreboard queue of expected bits is
// filled on each accepted load and drained as the DUT consumes bits.
module tb_piso_shift_tx;

  localparam int MSB = 4;

  logic clk;
  logic rst;
  piso_shift_tx_if #(.MSB(MSB)) bus ();

  piso_shift_tx #(.MSB(MSB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cycnt   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycnt);
    end
  endtask

  always @(posedge clk) cycnt <= cycnt + 1;

  // Reference model state
  bit   mon_on   = 1'b0;
  bit   m_active = 1'b0;
  int   m_left   = 0;
  bit   m_fd     = 1'b0;
  bit   m_rdy;
  bit   m_consume;
  logic exp_q[$];
  logic obs_bits[$];
  int   fd_cnt   = 0;
  int   fd_at    = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      chk("busy",       32'(bus.busy),       32'(m_active));
      chk("q_valid",    32'(bus.q_valid),    32'(m_active));
      chk("frame_done", 32'(bus.frame_done), 32'(m_fd));
      m_rdy = !m_active || (bus.en && (m_left == 1));
      chk("load_ready", 32'(bus.load_ready), 32'(m_rdy));
      if (m_active && (exp_q.size() > 0)) chk("q", 32'(bus.q), 32'(exp_q[0]));
      else if (!m_active)                 chk("q_idle", 32'(bus.q), 32'(0));
      if (bus.frame_done === 1'b1) begin
        fd_cnt++;
        fd_at = cycnt;
      end

      if (rst) begin
        m_active = 1'b0;
        m_left   = 0;
        m_fd     = 1'b0;
        exp_q.delete();
      end else begin
        m_consume = m_active && bus.en;
        m_fd      = m_consume && (m_left == 1);
        if (m_consume) begin
          obs_bits.push_back(bus.q);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_left--;
          if (m_left == 0) m_active = 1'b0;
        end
        if (bus.load_valid && m_rdy) begin
          m_active = 1'b1;
          m_left   = MSB;
          for (int i = 0; i < MSB; i++)
            exp_q.push_back(bus.dir ? bus.din[MSB-1-i] : bus.din[i]);
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic lv, input logic [MSB-1:0] d,
                     input logic dr, input logic e);
    rst            = r;
    bus.load_valid = lv;
    bus.din        = d;
    bus.dir        = dr;
    bus.en         = e;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_bits.delete();
    fd_cnt = 0;
    fd_at  = 0;
  endtask

  function automatic logic [31:0] packed_obs();
    logic [31:0] v;
    v = '0;
    foreach (obs_bits[i]) v = (v << 1) | 32'(obs_bits[i]);
    return v;
  endfunction

  int t_load;

  initial begin
    rst = 1'b1;
    bus.load_valid = 1'b0;
    bus.din = '0;
    bus.dir = 1'b0;
    bus.en  = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, 0, 4'b0000, 0, 0);
    mon_on = 1'b1;
    cyc(0, 0, 4'b0000, 0, 1);

    // MSB first, continuous enable
    clear_obs();
    cyc(0, 1, 4'b1011, 1, 1);
    t_load = cycnt;
    repeat (4) cyc(0, 0, 4'b0000, 0, 1);
    cyc(0, 0, 4'b0000, 0, 0);
    chk("t1_len", 32'(obs_bits.size()), 32'd4);
    chk("t1_stream", packed_obs(), 32'b1011);
    chk("t1_fd_cnt", 32'(fd_cnt), 32'd1);
    chk("t1_fd_lat", 32'(fd_at - t_load), 32'd4);

    // LSB first, dir toggled mid-frame
    clear_obs();
    cyc(0, 1, 4'b1011, 0, 1);
    cyc(0, 0, 4'b0100, 1, 1);
    cyc(0, 0, 4'b0010, 0, 1);
    cyc(0, 0, 4'b1111, 1, 1);
    cyc(0, 0, 4'b0000, 1, 1);
    cyc(0, 0, 4'b0000, 0, 0);
    chk("t2_len", 32'(obs_bits.size()), 32'd4);
    chk("t2_stream", packed_obs(), 32'b1101);
    chk("t2_fd_cnt", 32'(fd_cnt), 32'd1);

    // Stall with en=0 for two cycles
    clear_obs();
    cyc(0, 1, 4'b0110, 1, 1);
    t_load = cycnt;
    cyc(0, 0, 4'b0000, 0, 1);
    cyc(0, 0, 4'b0000, 0, 0);
    cyc(0, 0, 4'b0000, 0, 0);
    cyc(0, 0, 4'b0000, 0, 1);
    cyc(0, 0, 4'b0000, 0, 1);
    cyc(0, 0, 4'b0000, 0, 1);
    cyc(0, 0, 4'b0000, 0, 0);
    chk("t3_len", 32'(obs_bits.size()), 32'd4);
    chk("t3_stream", packed_obs(), 32'b0110);
    chk("t3_fd_lat", 32'(fd_at - t_load), 32'd6);

    // Back-to-back frames, second load on the last-bit cycle
    clear_obs();
    cyc(0, 1, 4'b1000, 1, 1);
    repeat (3) cyc(0, 0, 4'b0000, 1, 1);
    cyc(0, 1, 4'b0001, 1, 1);
    repeat (4) cyc(0, 0, 4'b0000, 1, 1);
    cyc(0, 0, 4'b0000, 0, 0);
    cyc(0, 0, 4'b0000, 0, 0);
    chk("t4_len", 32'(obs_bits.size()), 32'd8);
    chk("t4_stream", packed_obs(), 32'b10000001);
    chk("t4_fd_cnt", 32'(fd_cnt), 32'd2);

    // load_valid while busy is ignored
    clear_obs();
    cyc(0, 1, 4'b1011, 1, 1);
    cyc(0, 0, 4'b0000, 1, 1);
    cyc(0, 1, 4'b1111, 0, 1);
    cyc(0, 0, 4'b0000, 1, 1);
    cyc(0, 0, 4'b0000, 1, 1);
    cyc(0, 0, 4'b0000, 0, 0);
    cyc(0, 0, 4'b0000, 0, 0);
    chk("t5_len", 32'(obs_bits.size()), 32'd4);
    chk("t5_stream", packed_obs(), 32'b1011);
    chk("t5_fd_cnt", 32'(fd_cnt), 32'd1);

    // Reset mid-frame, with a competing load on the reset edge
    clear_obs();
    cyc(0, 1, 4'b1011, 1, 1);
    cyc(0, 0, 4'b0000, 1, 1);
    cyc(0, 0, 4'b0000, 1, 1);
    cyc(1, 1, 4'b1111, 1, 1);
    cyc(0, 0, 4'b0000, 0, 1);
    cyc(0, 0, 4'b0000, 0, 0);
    chk("t6_len", 32'(obs_bits.size()), 32'd2);
    chk("t6_stream", packed_obs(), 32'b10);
    chk("t6_fd_cnt", 32'(fd_cnt), 32'd0);

    // Fresh frame after reset
    clear_obs();
    cyc(0, 1, 4'b0110, 0, 1);
    repeat (4) cyc(0, 0, 4'b0000, 0, 1);
    cyc(0, 0, 4'b0000, 0, 0);
    chk("t7_len", 32'(obs_bits.size()), 32'd4);
    chk("t7_stream", packed_obs(), 32'b0110);
    chk("t7_fd_cnt", 32'(fd_cnt), 32'd1);

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
